// File: rtl/axis_peak_window_pkg.sv
// Shared width helpers for the peak-window search block.
package axis_peak_window_pkg;

   // Lane magnitude width produced by the upstream complex-abs serializer.
   function automatic int abs_width_f(input int channel_width);
      return (channel_width <= 32) ? 16 : 32;
   endfunction

   // Number of bits needed to hold max_val (minimum 1).
   function automatic int bits_for_f(input int max_val);
      int b;
      b = 1;
      for (int i = 1; i < 32; i++) begin
         if ((64'(1) << b) <= 64'(max_val)) b = i + 1;
      end
      return b;
   endfunction

endpackage

// File: rtl/axis_peak_window_sum.sv
// Combinational energy sum: adds the low ABS_WIDTH bits of every channel lane.
module axis_peak_window_sum
   import axis_peak_window_pkg::*;
#(
   parameter int NUM_CHANNELS  = 4,
   parameter int CHANNEL_WIDTH = 32,
   parameter int ABS_WIDTH     = 16,
   parameter int SUM_WIDTH     = 18
) (
   input  logic [CHANNEL_WIDTH*NUM_CHANNELS-1:0] abs_in,
   output logic [SUM_WIDTH-1:0]                  sum_out
);

   logic [SUM_WIDTH-1:0] lane_ext [NUM_CHANNELS];
   logic                 unused_abs_bits;

   // Upper bits of each lane carry no magnitude information and are dropped.
   generate
      for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_lane
         assign lane_ext[gi] = SUM_WIDTH'(abs_in[gi*CHANNEL_WIDTH +: ABS_WIDTH]);
      end
   endgenerate

   assign unused_abs_bits = ^abs_in;

   always_comb begin
      sum_out = '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         sum_out = sum_out + lane_ext[i];
      end
   end

endmodule

// File: rtl/axis_peak_window.sv
// Per-window max-energy beat search; emits peak beat data, energy and index.
// Optional build macro PEAK_THRESHOLD_EN adds s_threshold and drops sub-threshold windows.
module axis_peak_window
   import axis_peak_window_pkg::*;
#(
   parameter int NUM_CHANNELS  = 4,
   parameter int CHANNEL_WIDTH = 32,
   parameter int WINDOW_LEN    = 64,
   localparam int ABS_WIDTH    = abs_width_f(CHANNEL_WIDTH),
   localparam int SUM_WIDTH    = ABS_WIDTH + bits_for_f(NUM_CHANNELS - 1),
   localparam int IDX_WIDTH    = bits_for_f(WINDOW_LEN - 1),
   localparam int DATA_WIDTH   = CHANNEL_WIDTH * NUM_CHANNELS
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata_abs,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [SUM_WIDTH-1:0]  m_axis_tpeak,
`ifdef PEAK_THRESHOLD_EN
   output logic [IDX_WIDTH-1:0]  m_axis_tindex,
   input  logic [SUM_WIDTH-1:0]  s_threshold
`else
   output logic [IDX_WIDTH-1:0]  m_axis_tindex
`endif
);

   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(WINDOW_LEN - 1);

   logic [IDX_WIDTH-1:0]  count_q, count_d;
   logic [SUM_WIDTH-1:0]  best_sum_q, best_sum_d;
   logic [IDX_WIDTH-1:0]  best_idx_q, best_idx_d;
   logic [DATA_WIDTH-1:0] best_data_q, best_data_d;
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic [SUM_WIDTH-1:0]  out_peak_q, out_peak_d;
   logic [IDX_WIDTH-1:0]  out_idx_q, out_idx_d;

   logic [SUM_WIDTH-1:0]  beat_sum;
   logic                  beat_last;
   logic                  beat_accept;
   logic                  beat_better;
   logic [SUM_WIDTH-1:0]  winner_sum;
   logic                  emit_ok;

   axis_peak_window_sum #(
      .NUM_CHANNELS  (NUM_CHANNELS),
      .CHANNEL_WIDTH (CHANNEL_WIDTH),
      .ABS_WIDTH     (ABS_WIDTH),
      .SUM_WIDTH     (SUM_WIDTH)
   ) u_sum (
      .abs_in  (s_axis_tdata_abs),
      .sum_out (beat_sum)
   );

   assign beat_last     = (count_q == LAST_IDX);
   // Only the window-closing beat needs a free output register.
   assign s_axis_tready = ~beat_last | ~out_valid_q | m_axis_tready;
   assign beat_accept   = s_axis_tvalid & s_axis_tready;
   assign beat_better   = (beat_sum > best_sum_q);
   assign winner_sum    = beat_better ? beat_sum : best_sum_q;

`ifdef PEAK_THRESHOLD_EN
   assign emit_ok = (winner_sum >= s_threshold);
`else
   assign emit_ok = 1'b1;
`endif

   always_comb begin
      count_d     = count_q;
      best_sum_d  = best_sum_q;
      best_idx_d  = best_idx_q;
      best_data_d = best_data_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_peak_d  = out_peak_q;
      out_idx_d   = out_idx_q;

      if (out_valid_q && m_axis_tready) begin
         out_valid_d = 1'b0;
      end

      if (beat_accept) begin
         count_d = beat_last ? '0 : count_q + IDX_WIDTH'(1);

         // Strict compare so ties keep the earliest beat.
         if ((count_q == '0) || beat_better) begin
            best_sum_d  = beat_sum;
            best_idx_d  = count_q;
            best_data_d = s_axis_tdata;
         end

         if (beat_last && emit_ok) begin
            out_valid_d = 1'b1;
            out_peak_d  = winner_sum;
            out_idx_d   = beat_better ? count_q : best_idx_q;
            out_data_d  = beat_better ? s_axis_tdata : best_data_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q     <= '0;
         best_sum_q  <= '0;
         best_idx_q  <= '0;
         best_data_q <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_peak_q  <= '0;
         out_idx_q   <= '0;
      end else begin
         count_q     <= count_d;
         best_sum_q  <= best_sum_d;
         best_idx_q  <= best_idx_d;
         best_data_q <= best_data_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_peak_q  <= out_peak_d;
         out_idx_q   <= out_idx_d;
      end
   end

   assign m_axis_tvalid = out_valid_q;
   assign m_axis_tdata  = out_data_q;
   assign m_axis_tpeak  = out_peak_q;
   assign m_axis_tindex = out_idx_q;

endmodule
